amm_mem_responder: RTL and testbench
====================================

# amm_mem_responder

Avalon-MM slave memory model answering the memory-side master port of the checker (address/read/write/writedata/burstcount/byteenable in, waitrequest/readdata/readdatavalid out). It stores data in an internal word-addressed RAM, accepts write and read bursts, returns read data after a fixed pipeline latency, and flags master protocol violations. It closes the loop in system benches and on-chip self-test builds, so the checker can run against a known-good memory with optional deliberate data corruption.

## Interface
Parameters:
- AMM_ADDR_W, from rtl_settings_pkg: word address width.
- AMM_DATA_W, from rtl_settings_pkg: data width.
- AMM_BURST_W, from rtl_settings_pkg: burstcount width.
- DATA_B_W, AMM_DATA_W/8: byteenable width.
- MEM_ADDR_W, 10: RAM depth is 2**MEM_ADDR_W words.
- READ_LATENCY, 2: cycles from read beat issue to readdatavalid; legal range 1..8.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- address_i  in  AMM_ADDR_W  word address of burst start.
- read_i  in  1  read burst request.
- write_i  in  1  write beat.
- writedata_i  in  AMM_DATA_W  write data.
- burstcount_i  in  AMM_BURST_W  beats in burst; 0 treated as 1.
- byteenable_i  in  DATA_B_W  per-byte write enable.
- waitrequest_o  out  1  command stall.
- readdata_o  out  AMM_DATA_W  read data.
- readdatavalid_o  out  1  readdata_o valid.
- inj_en_i  in  1  error injection enable.
- inj_addr_i  in  MEM_ADDR_W  RAM index whose read data is corrupted.
- protocol_err_o  out  1  sticky master-protocol violation flag.

## Operation
- States: INIT, IDLE, WR_BURST, RD_BURST. Reset state INIT.
- waitrequest_o = 1 in INIT and RD_BURST, else 0. A command is accepted when read_i or write_i is high and waitrequest_o is low at a rising edge.
- INIT -> IDLE on the first edge after reset release.
- IDLE, write accepted: write beat to RAM[address_i[MEM_ADDR_W-1:0]] with byteenable_i (unenabled bytes keep old value). If effective burst > 1: latch next index = index+1, remaining = burst-1, go WR_BURST.
- IDLE, read accepted: latch index and count = effective burst, go RD_BURST.
- IDLE, read_i and write_i both high: write is served, read is ignored, protocol_err_o set.
- WR_BURST: each write_i beat writes at the current index, then index+1 and remaining-1. address_i and burstcount_i are ignored. Remaining reaching 0 -> IDLE. read_i high -> protocol_err_o set and read ignored.
- RD_BURST: one beat issued per cycle from the current index, then index+1. After the last beat issues -> IDLE. Commands are stalled the whole time, and the next read can be accepted on the first IDLE cycle.
- Index arithmetic is MEM_ADDR_W bits wide and wraps from 2**MEM_ADDR_W-1 to 0. Upper address bits are ignored.
- A read beat issued in the cycle after a write beat to the same index returns the new data.
- RAM contents are not reset and power up undefined. A rst_i pulse mid-burst aborts the burst, clears the read pipeline and returns to INIT. RAM keeps its contents.
- protocol_err_o is cleared only by rst_i.

## Timing
- Reset values: waitrequest_o=1, readdatavalid_o=0, readdata_o=0, protocol_err_o=0.
- Read accepted at edge N. Beat k (k=0..count-1) has readdatavalid_o=1 in the cycle after edge N+k+READ_LATENCY. Beats are contiguous with no gaps.
- Between beats, readdatavalid_o=0 and readdata_o holds its last value.
- A write is visible to reads issued from the edge after it is accepted.
- protocol_err_o rises in the cycle after the violating edge.

## Configuration
- MEM_RESPONDER_ERR_INJECT_EN defined: a read beat from index == inj_addr_i while inj_en_i=1 returns data with bit 0 inverted. RAM contents are unaffected.
- Undefined: inj_en_i and inj_addr_i are ignored and the injection logic is absent.

## Test plan
- Reset: rst_i held 5 cycles -> waitrequest_o=1, readdatavalid_o=0 and protocol_err_o=0 throughout; waitrequest_o=0 on the cycle after the first post-release edge.
- Write 0xDEADBEEF (32-bit data) to address 5 with byteenable 0xF, then read burst 1 at edge N -> readdata_o=0xDEADBEEF with valid exactly in the cycle after edge N+2 (READ_LATENCY=2).
- Write burst 4 at address 10 with data 1,2,3,4, then a write at address 11 with byteenable 0x1 and data 0xFF -> read burst 4 returns 1,0xFF,3,4 on 4 consecutive valid cycles, with waitrequest_o=1 for 4 cycles.
- Wrap: write burst 3 at address 1022 (MEM_ADDR_W=10) -> reads at 1022, 1023 and 0 return the burst data in order.
- Violations: read_i asserted during WR_BURST, and separately read_i with write_i in IDLE -> protocol_err_o=1 sticky; write data still stored, no readdatavalid_o generated.
- With MEM_RESPONDER_ERR_INJECT_EN, inj_en_i=1, inj_addr_i=7: store 0x10 at 7 -> read returns 0x11. inj_en_i=0 -> read returns 0x10. Without the macro -> read returns 0x10 in both cases.

Source files
------------

// File: rtl/amm_mem_responder.sv
// Avalon-MM slave RAM model with sticky protocol_err_o; read-data corruption is built only with MEM_RESPONDER_ERR_INJECT_EN.
// Read beat k valid READ_LATENCY+k cycles after accept; waitrequest_o stalls commands in INIT and for the whole read burst.
package rtl_settings_pkg;
    localparam int AMM_ADDR_W  = 24;
    localparam int AMM_DATA_W  = 32;
    localparam int AMM_BURST_W = 4;
endpackage

module amm_mem_responder #(
    parameter int AMM_ADDR_W   = rtl_settings_pkg::AMM_ADDR_W,
    parameter int AMM_DATA_W   = rtl_settings_pkg::AMM_DATA_W,
    parameter int AMM_BURST_W  = rtl_settings_pkg::AMM_BURST_W,
    parameter int DATA_B_W     = AMM_DATA_W / 8,
    parameter int MEM_ADDR_W   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AMM_ADDR_W-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [AMM_DATA_W-1:0]  writedata_i,
    input  logic [AMM_BURST_W-1:0] burstcount_i,
    input  logic [DATA_B_W-1:0]    byteenable_i,
    output logic                   waitrequest_o,
    output logic [AMM_DATA_W-1:0]  readdata_o,
    output logic                   readdatavalid_o,
    input  logic                   inj_en_i,
    input  logic [MEM_ADDR_W-1:0]  inj_addr_i,
    output logic                   protocol_err_o
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR_BURST, ST_RD_BURST} state_t;

    state_t                 state_q, state_d;
    logic [MEM_ADDR_W-1:0]  idx_q, idx_d, wr_idx, cmd_idx;
    logic [AMM_BURST_W-1:0] cnt_q, cnt_d, eff_burst;
    logic                   err_q, err_d, wait_q, wait_d;
    logic                   wr_en, issue;
    logic [AMM_DATA_W-1:0]  rd_dat;
    logic [AMM_DATA_W-1:0]  mem [2**MEM_ADDR_W];
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [AMM_DATA_W-1:0]  pipe_dat_q [READ_LATENCY];
    logic                   unused_sink;

    assign cmd_idx     = address_i[MEM_ADDR_W-1:0];
    assign eff_burst   = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
    assign unused_sink = &{1'b0, address_i, inj_en_i, inj_addr_i};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        issue   = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                // A simultaneous read is dropped in favour of the write.
                if (write_i) begin
                    wr_en  = 1'b1;
                    wr_idx = cmd_idx;
                    if (read_i) err_d = 1'b1;
                    if (eff_burst > AMM_BURST_W'(1)) begin
                        idx_d   = cmd_idx + MEM_ADDR_W'(1);
                        cnt_d   = eff_burst - AMM_BURST_W'(1);
                        state_d = ST_WR_BURST;
                    end
                end else if (read_i) begin
                    idx_d   = cmd_idx;
                    cnt_d   = eff_burst;
                    state_d = ST_RD_BURST;
                end
            end
            ST_WR_BURST: begin
                if (read_i) err_d = 1'b1;
                if (write_i) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + MEM_ADDR_W'(1);
                    cnt_d = cnt_q - AMM_BURST_W'(1);
                    if (cnt_q == AMM_BURST_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_RD_BURST: begin
                issue = 1'b1;
                idx_d = idx_q + MEM_ADDR_W'(1);
                cnt_d = cnt_q - AMM_BURST_W'(1);
                if (cnt_q == AMM_BURST_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
        wait_d = (state_d == ST_INIT) || (state_d == ST_RD_BURST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    // RAM has no reset so its contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_B_W; b++) begin
                if (byteenable_i[b]) mem[wr_idx][b*8 +: 8] <= writedata_i[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_dat = mem[idx_q];
`ifdef MEM_RESPONDER_ERR_INJECT_EN
        if (inj_en_i && (idx_q == inj_addr_i)) rd_dat[0] = ~rd_dat[0];
`endif
    end

    // Data stages only load on a valid beat, so the last stage holds between beats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_dat_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= issue;
            if (issue) pipe_dat_q[0] <= rd_dat;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
        end
    end

    assign waitrequest_o   = wait_q;
    assign readdatavalid_o = pipe_vld_q[READ_LATENCY-1];
    assign readdata_o      = pipe_dat_q[READ_LATENCY-1];
    assign protocol_err_o  = err_q;

endmodule

// File: tb/tb_amm_mem_responder.sv
// Randomized bench for amm_mem_responder: array reference model plus cycle-stamped read scoreboard.
// Inputs driven 1 time unit after the rising edge; outputs checked on the falling edge.
module tb_amm_mem_responder;

    localparam int AW    = 24;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int MW    = 10;
    localparam int RL    = 2;
    localparam int DEPTH = 1024;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [AW-1:0] address_i = '0;
    logic          read_i = 1'b0;
    logic          write_i = 1'b0;
    logic [DW-1:0] writedata_i = '0;
    logic [BW-1:0] burstcount_i = '0;
    logic [3:0]    byteenable_i = '0;
    logic          waitrequest_o;
    logic [DW-1:0] readdata_o;
    logic          readdatavalid_o;
    logic          inj_en_i = 1'b0;
    logic [MW-1:0] inj_addr_i = '0;
    logic          protocol_err_o;

    amm_mem_responder #(
        .AMM_ADDR_W(AW), .AMM_DATA_W(DW), .AMM_BURST_W(BW),
        .DATA_B_W(4), .MEM_ADDR_W(MW), .READ_LATENCY(RL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .writedata_i(writedata_i), .burstcount_i(burstcount_i),
        .byteenable_i(byteenable_i), .waitrequest_o(waitrequest_o),
        .readdata_o(readdata_o), .readdatavalid_o(readdatavalid_o),
        .inj_en_i(inj_en_i), .inj_addr_i(inj_addr_i), .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        longint      cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    longint      cyc = 0;
    bit          err_exp = 1'b0;
    logic [31:0] last_dat = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        bit   exp_v;
        exp_t e;
        exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        chk("rdvalid", readdatavalid_o, exp_v);
        if (exp_v) begin
            e = exp_q.pop_front();
            chk("rdata", readdata_o, e.dat);
            last_dat = e.dat;
        end else begin
            chk("rdata_hold", readdata_o, last_dat);
        end
        chk("protocol_err", protocol_err_o, err_exp);
    end

    function automatic logic [31:0] exp_rd(input int unsigned idx);
        logic [31:0] d;
        d = ref_mem[idx];
`ifdef MEM_RESPONDER_ERR_INJECT_EN
        if (inj_en_i && (idx == int'(inj_addr_i))) d[0] = ~d[0];
`endif
        return d;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (waitrequest_o === 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (waitrequest_o !== 1'b0) chk("wait_timeout", waitrequest_o, 0);
    endtask

    task automatic wr_burst(input int unsigned addr, input int n, input logic [3:0] be,
                            input logic [31:0] base, input bit rnd, input bit viol);
        int unsigned idx;
        logic [31:0] d;
        wait_ready();
        for (int i = 0; i < n; i++) begin
            if (i > 0 && rnd) begin
                while ($urandom_range(0, 3) == 0) step();
            end
            d = rnd ? $urandom : base + i;
            idx = (addr + i) % DEPTH;
            write_i = 1'b1;
            writedata_i = d;
            byteenable_i = be;
            read_i = viol && (i == ((n > 1) ? 1 : 0));
            address_i = (i == 0) ? AW'(addr) : AW'($urandom);
            if (i == 0) burstcount_i = (n == 1) ? BW'($urandom_range(0, 1)) : BW'(n);
            else        burstcount_i = BW'($urandom);
            step();
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
            end
            if (read_i) err_exp = 1'b1;
            write_i = 1'b0;
            read_i = 1'b0;
        end
    endtask

    task automatic do_read(input int unsigned addr, input int n);
        int     eff;
        longint acc;
        eff = (n == 0) ? 1 : n;
        wait_ready();
        read_i = 1'b1;
        address_i = AW'(addr);
        burstcount_i = BW'(n);
        acc = cyc + 1;
        for (int k = 0; k < eff; k++)
            exp_q.push_back('{cyc: acc + k + RL, dat: exp_rd((addr + k) % DEPTH)});
        step();
        read_i = 1'b0;
        address_i = AW'($urandom);
        burstcount_i = BW'($urandom);
        for (int k = 0; k < eff; k++) begin
            chk("wreq_rd_burst", waitrequest_o, 1);
            step();
        end
        chk("wreq_after_rd", waitrequest_o, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        write_i = 1'b0;
        read_i = 1'b0;
        exp_q.delete();
        err_exp = 1'b0;
        last_dat = '0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_wreq", waitrequest_o, 1);
            step();
        end
        rst_i = 1'b0;
        #1;
        chk("init_wreq", waitrequest_o, 1);
        step();
        chk("idle_wreq", waitrequest_o, 0);
    endtask

    initial begin
        #1;
        do_reset();

        for (int a = 0; a < DEPTH; a += 15)
            wr_burst(a, (DEPTH - a < 15) ? DEPTH - a : 15, 4'hF, 0, 1'b1, 1'b0);

        wr_burst(5, 1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        do_read(5, 1);
        drain();
        chk("single_read", readdata_o, 32'hDEADBEEF);

        wr_burst(10, 4, 4'hF, 32'd1, 1'b0, 1'b0);
        wr_burst(11, 1, 4'h1, 32'hFF, 1'b0, 1'b0);
        do_read(10, 4);
        drain();
        chk("burst_last", readdata_o, 32'd4);

        wr_burst(1022, 3, 4'hF, 32'hA0, 1'b0, 1'b0);
        do_read(1022, 1);
        do_read(1023, 1);
        do_read(0, 1);
        do_read(1022, 3);
        drain();
        chk("wrap_last", readdata_o, 32'hA2);

        wr_burst(7, 1, 4'hF, 32'h10, 1'b0, 1'b0);
        inj_en_i = 1'b1;
        inj_addr_i = 7;
        do_read(7, 1);
        drain();
`ifdef MEM_RESPONDER_ERR_INJECT_EN
        chk("inj_on", readdata_o, 32'h11);
`else
        chk("inj_on", readdata_o, 32'h10);
`endif
        do_read(6, 3);
        drain();
        inj_en_i = 1'b0;
        do_read(7, 1);
        drain();
        chk("inj_off", readdata_o, 32'h10);

        repeat (150) begin
            if ($urandom_range(0, 2) == 0)
                wr_burst($urandom, $urandom_range(1, 15), 4'($urandom), 0, 1'b1, 1'b0);
            else
                do_read($urandom, $urandom_range(0, 15));
        end
        drain();

        wait_ready();
        read_i = 1'b1;
        address_i = AW'(100);
        burstcount_i = BW'(8);
        for (int k = 0; k < 8; k++)
            exp_q.push_back('{cyc: cyc + 1 + k + RL, dat: exp_rd(100 + k)});
        step();
        read_i = 1'b0;
        step();
        step();
        do_reset();
        do_read(100, 8);
        drain();

        wr_burst(200, 4, 4'hF, 0, 1'b1, 1'b1);
        do_read(200, 4);
        drain();
        chk("err_wr_burst", protocol_err_o, 1);

        do_reset();
        wr_burst(300, 1, 4'hF, 32'h5A5A, 1'b0, 1'b1);
        step();
        step();
        chk("err_idle_both", protocol_err_o, 1);
        do_read(300, 1);
        drain();
        chk("both_write_kept", readdata_o, 32'h5A5A);

        do_reset();
        chk("err_cleared", protocol_err_o, 0);
        do_read(300, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
